// File: rtl/datapath.sv
`default_nettype none
// ============================================================================
// Module   : datapath
// Brief    : 8-bit PC/AC datapath with combinational ALU, flags and LED/switch I/O.
//            Build option: DATAPATH_SWITCH_SYNC_EN adds a 2-flop switch synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
module datapath (
  input  logic       clk,
  input  logic       reset,
  input  logic       pc_load_en,
  input  logic       pc_inc_en,
  input  logic       ac_load_en,
  input  logic       flags_load_en,
  input  logic [3:0] alu_op,
  input  logic       alu_cin,
  input  logic       io_write_en,
  input  logic       io_read_en,
  input  logic [7:0] data_bus_in,
  input  logic [7:0] addr_bus_in,
  input  logic [3:0] in_switches,
  output logic [7:0] pc_out,
  output logic [7:0] ac_out,
  output logic [7:0] io_read_data,
  output logic [3:0] out_leds,
  output logic       flag_n,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_b,
  output logic       flag_v
);

  localparam logic [3:0] c_op_lda  = 4'b0000;
  localparam logic [3:0] c_op_add  = 4'b0001;
  localparam logic [3:0] c_op_sub  = 4'b0010;
  localparam logic [3:0] c_op_or   = 4'b0011;
  localparam logic [3:0] c_op_and  = 4'b0100;
  localparam logic [3:0] c_op_not  = 4'b0101;
  localparam logic [3:0] c_op_xor  = 4'b0110;
  localparam logic [3:0] c_op_rlc  = 4'b0111;
  localparam logic [3:0] c_op_shl  = 4'b1000;
  localparam logic [3:0] c_op_rrc  = 4'b1001;
  localparam logic [3:0] c_op_shr  = 4'b1010;

  localparam logic [7:0] c_addr_leds = 8'h00;
  localparam logic [7:0] c_addr_sw   = 8'h04;

  logic [7:0] r_pc;
  logic [7:0] r_ac;
  logic [7:0] r_io_read_data;
  logic [3:0] r_leds;
  logic       r_n, r_z, r_c, r_b, r_v;

  logic [8:0] w_sum;
  logic [8:0] w_diff;
  logic [7:0] w_result;
  logic       w_c, w_b, w_v;
  logic [3:0] w_sw_sync;

  assign w_sum  = {1'b0, r_ac} + {1'b0, data_bus_in} + {8'd0, alu_cin};
  // Bit 8 of the 9-bit difference is the unsigned borrow (A < B).
  assign w_diff = {1'b0, r_ac} - {1'b0, data_bus_in};

  always_comb begin
    w_result = r_ac;
    w_c      = 1'b0;
    w_b      = 1'b0;
    w_v      = 1'b0;
    case (alu_op)
      c_op_lda: w_result = data_bus_in;
      c_op_add: begin
        w_result = w_sum[7:0];
        w_c      = w_sum[8];
        w_v      = (r_ac[7] == data_bus_in[7]) && (w_sum[7] != r_ac[7]);
      end
      c_op_sub: begin
        w_result = w_diff[7:0];
        w_b      = w_diff[8];
        w_c      = ~w_diff[8];
        w_v      = (r_ac[7] != data_bus_in[7]) && (w_diff[7] != r_ac[7]);
      end
      c_op_or:  w_result = r_ac | data_bus_in;
      c_op_and: w_result = r_ac & data_bus_in;
      c_op_not: w_result = ~r_ac;
      c_op_xor: w_result = r_ac ^ data_bus_in;
      c_op_rlc: begin
        w_result = {r_ac[6:0], alu_cin};
        w_c      = r_ac[7];
      end
      c_op_shl: begin
        w_result = {r_ac[6:0], 1'b0};
        w_c      = r_ac[7];
      end
      c_op_rrc: begin
        w_result = {alu_cin, r_ac[7:1]};
        w_c      = r_ac[0];
      end
      c_op_shr: begin
        w_result = {1'b0, r_ac[7:1]};
        w_c      = r_ac[0];
      end
      default:  w_result = r_ac;
    endcase
  end

`ifdef DATAPATH_SWITCH_SYNC_EN
  logic [3:0] r_sw_meta;
  logic [3:0] r_sw_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_meta <= 4'd0;
      r_sw_sync <= 4'd0;
    end else begin
      r_sw_meta <= in_switches;
      r_sw_sync <= r_sw_meta;
    end
  end

  assign w_sw_sync = r_sw_sync;
`else
  assign w_sw_sync = in_switches;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= 8'd0;
    end else if (pc_load_en) begin
      r_pc <= data_bus_in;
    end else if (pc_inc_en) begin
      r_pc <= r_pc + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ac <= 8'd0;
    end else if (ac_load_en) begin
      r_ac <= w_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n <= 1'b0;
      r_z <= 1'b0;
      r_c <= 1'b0;
      r_b <= 1'b0;
      r_v <= 1'b0;
    end else if (flags_load_en) begin
      r_n <= w_result[7];
      r_z <= (w_result == 8'd0);
      r_c <= w_c;
      r_b <= w_b;
      r_v <= w_v;
    end
  end

  // LEDs capture the AC value present before this edge's possible AC update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_leds         <= 4'd0;
      r_io_read_data <= 8'd0;
    end else begin
      if (io_write_en && (addr_bus_in == c_addr_leds)) begin
        r_leds <= r_ac[3:0];
      end
      if (io_read_en) begin
        r_io_read_data <= (addr_bus_in == c_addr_sw) ? {4'b0000, w_sw_sync} : 8'h00;
      end
    end
  end

  assign pc_out       = r_pc;
  assign ac_out       = r_ac;
  assign io_read_data = r_io_read_data;
  assign out_leds     = r_leds;
  assign flag_n       = r_n;
  assign flag_z       = r_z;
  assign flag_c       = r_c;
  assign flag_b       = r_b;
  assign flag_v       = r_v;

endmodule
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath
// Brief    : Scoreboard bench for datapath; honours DATAPATH_SWITCH_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath;

`ifdef DATAPATH_SWITCH_SYNC_EN
  localparam bit c_sync = 1'b1;
`else
  localparam bit c_sync = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       pc_load_en, pc_inc_en, ac_load_en, flags_load_en;
  logic [3:0] alu_op;
  logic       alu_cin, io_write_en, io_read_en;
  logic [7:0] data_bus_in, addr_bus_in;
  logic [3:0] in_switches;
  logic [7:0] pc_out, ac_out, io_read_data;
  logic [3:0] out_leds;
  logic       flag_n, flag_z, flag_c, flag_b, flag_v;

  datapath u_dut (
    .clk          (clk),
    .reset        (reset),
    .pc_load_en   (pc_load_en),
    .pc_inc_en    (pc_inc_en),
    .ac_load_en   (ac_load_en),
    .flags_load_en(flags_load_en),
    .alu_op       (alu_op),
    .alu_cin      (alu_cin),
    .io_write_en  (io_write_en),
    .io_read_en   (io_read_en),
    .data_bus_in  (data_bus_in),
    .addr_bus_in  (addr_bus_in),
    .in_switches  (in_switches),
    .pc_out       (pc_out),
    .ac_out       (ac_out),
    .io_read_data (io_read_data),
    .out_leds     (out_leds),
    .flag_n       (flag_n),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .flag_b       (flag_b),
    .flag_v       (flag_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         target;
    logic [7:0] pc, ac, iord;
    logic [3:0] leds;
    logic [4:0] flags;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference state in plain integers
  int m_pc, m_ac, m_iord, m_leds, m_flags, m_sw_d1, m_sw_d2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp_v, $time);
  endtask

  function automatic logic [4:0] dut_flags();
    return {flag_n, flag_z, flag_c, flag_b, flag_v};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ac = 0; m_iord = 0; m_leds = 0; m_flags = 0;
    m_sw_d1 = 0; m_sw_d2 = 0;
  endtask

  // Called at posedge+1: drive inputs, predict state after the coming edge, consume one cycle.
  task automatic step(input bit pl, input bit pi, input bit al, input bit fl,
                      input int op, input bit cin, input bit iw, input bit ir,
                      input int db, input int ab, input int sw);
    int   a, res, c, bo, v, sa, sb, t, swv;
    exp_t e;
    pc_load_en = pl; pc_inc_en = pi; ac_load_en = al; flags_load_en = fl;
    alu_op = 4'(op); alu_cin = cin; io_write_en = iw; io_read_en = ir;
    data_bus_in = 8'(db); addr_bus_in = 8'(ab); in_switches = 4'(sw);

    a  = m_ac; c = 0; bo = 0; v = 0;
    sa = (a  > 127) ? a  - 256 : a;
    sb = (db > 127) ? db - 256 : db;
    case (op)
      0:  res = db;
      1:  begin t = a + db + cin; res = t % 256; c = (t > 255);
                t = sa + sb + cin; v = (t > 127 || t < -128); end
      2:  begin res = (a - db + 256) % 256; bo = (a < db); c = !bo;
                t = sa - sb; v = (t > 127 || t < -128); end
      3:  res = a | db;
      4:  res = a & db;
      5:  res = 255 - a;
      6:  res = a ^ db;
      7:  begin res = (a * 2 + cin) % 256; c = (a >= 128); end
      8:  begin res = (a * 2) % 256;       c = (a >= 128); end
      9:  begin res = a / 2 + cin * 128;   c = a % 2; end
      10: begin res = a / 2;               c = a % 2; end
      default: res = a;
    endcase

    swv = c_sync ? m_sw_d2 : sw;
    m_sw_d2 = m_sw_d1;
    m_sw_d1 = sw;
    if (fl) m_flags = (res / 128) * 16 + (res == 0) * 8 + c * 4 + bo * 2 + v;
    if (al) m_ac = res;
    if (pl) m_pc = db;
    else if (pi) m_pc = (m_pc + 1) % 256;
    if (iw && ab == 0) m_leds = a % 16;
    if (ir) m_iord = (ab == 4) ? swv : 0;

    e.target = cyc + 1;
    e.pc = 8'(m_pc); e.ac = 8'(m_ac); e.iord = 8'(m_iord);
    e.leds = 4'(m_leds); e.flags = 5'(m_flags);
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic lda(input int v);
    step(0, 0, 1, 0, 0, 0, 0, 0, v, 0, 0);
  endtask

  task automatic alu(input int op, input int db, input bit cin);
    step(0, 0, 1, 1, op, cin, 0, 0, db, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc"},    pc_out, 8'h00);
    chk({tag, "_ac"},    ac_out, 8'h00);
    chk({tag, "_iord"},  io_read_data, 8'h00);
    chk({tag, "_leds"},  {4'h0, out_leds}, 8'h00);
    chk({tag, "_flags"}, {3'b000, dut_flags()}, 8'h00);
  endtask

  task automatic rand_step();
    int ab;
    case ($urandom_range(0, 2))
      0: ab = 0;
      1: ab = 4;
      default: ab = $urandom_range(0, 255);
    endcase
    step($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
         $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
         $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255),
         ab, $urandom_range(0, 15));
  endtask

  // Monitor: compares the DUT against every prediction targeting the current edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #3;
      while (sb_q.size() > 0 && sb_q[0].target <= cyc) begin
        e = sb_q.pop_front();
        if (e.target < cyc) begin
          chk("sb_missed", 8'(e.target), 8'(cyc));
        end else begin
          chk("sb_pc",    pc_out, e.pc);
          chk("sb_ac",    ac_out, e.ac);
          chk("sb_iord",  io_read_data, e.iord);
          chk("sb_leds",  {4'h0, out_leds}, {4'h0, e.leds});
          chk("sb_flags", {3'b000, dut_flags()}, {3'b000, e.flags});
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    pc_load_en = 0; pc_inc_en = 0; ac_load_en = 0; flags_load_en = 0;
    alu_op = 0; alu_cin = 0; io_write_en = 0; io_read_en = 0;
    data_bus_in = 0; addr_bus_in = 0; in_switches = 0;
    model_reset();
    #2;
    chk_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pc_inc", pc_out, 8'h01);
    step(1, 1, 0, 0, 0, 0, 0, 0, 8'hA5, 0, 0);
    chk("pc_load", pc_out, 8'hA5);
    step(1, 0, 0, 0, 0, 0, 0, 0, 8'hFF, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pc_wrap", pc_out, 8'h00);

    lda(8'h7F); alu(1, 8'h01, 0);
    chk("add_ovf_ac", ac_out, 8'h80);
    chk("add_ovf_fl", {3'b000, dut_flags()}, 8'b10001);
    lda(8'hFF); alu(1, 8'h01, 0);
    chk("add_cy_ac", ac_out, 8'h00);
    chk("add_cy_fl", {3'b000, dut_flags()}, 8'b01100);
    lda(8'h00); alu(2, 8'h01, 0);
    chk("sub_bo_ac", ac_out, 8'hFF);
    chk("sub_bo_fl", {3'b000, dut_flags()}, 8'b10010);
    lda(50); alu(2, 20, 0);
    chk("sub_ok_ac", ac_out, 8'd30);
    chk("sub_ok_fl", {3'b000, dut_flags()}, 8'b00100);

    lda(8'h81); alu(7, 0, 1);
    chk("rlc_ac", ac_out, 8'h03);
    chk("rlc_c", {7'd0, flag_c}, 8'h01);
    lda(8'h81); alu(10, 0, 0);
    chk("shr_ac", ac_out, 8'h40);
    chk("shr_c", {7'd0, flag_c}, 8'h01);
    lda(8'hF0); alu(5, 8'h33, 0);
    chk("not_ac", ac_out, 8'h0F);

    lda(8'hDA);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0);
    chk("led_write", {4'h0, out_leds}, 8'h0A);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h01, 0);
    chk("led_bad_addr", {4'h0, out_leds}, 8'h0A);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h04, 4'hC);
    chk("sw_read", io_read_data, 8'h0C);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 8'h00, 4'hC);
    chk("rw_same_iord", io_read_data, 8'h00);

    for (int i = 0; i < 300; i++) rand_step();

    // Asynchronous reset mid-operation, away from any clock edge
    lda(8'h5A);
    #4;
    ac_load_en = 1'b1;
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 100; i++) rand_step();

    pc_load_en = 0; pc_inc_en = 0; ac_load_en = 0; flags_load_en = 0;
    io_write_en = 0; io_read_en = 0;
    repeat (3) @(posedge clk);
    #5;
    chk("sb_drain", 8'(sb_q.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
